// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a credit-limited FIFO, in-order imem port and redirect flush
// Ports: clk/reset; redirect_valid/redirect_pc; imem_req_valid/addr/ready; imem_resp_valid/data;
//        inst_valid/data/pc/ready downstream handshake.
// Optional: FETCH_BYPASS_EN drives inst_* straight from a response when the FIFO is empty.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [31:0]   fetch_pc, resp_pc;
    logic [31:0]   buf_pc   [DEPTH];
    logic [31:0]   buf_data [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, inflight, discard;
    logic [CW:0]   used;
    logic          fire, resp_keep, head_valid, bypass, push, pop;
    always_comb begin
        // Every outstanding request owns a FIFO slot, so responses can never overflow the buffer.
        used           = {1'b0, count} + {1'b0, inflight};
        imem_req_valid = !reset && !redirect_valid && (used < (CW+1)'(DEPTH));
        imem_req_addr  = fetch_pc;
        fire           = imem_req_valid && imem_req_ready;
        resp_keep      = imem_resp_valid && !redirect_valid && (discard == '0);
        head_valid     = (count != '0);
`ifdef FETCH_BYPASS_EN
        bypass         = resp_keep && !head_valid;
`else
        bypass         = 1'b0;
`endif
        inst_valid     = head_valid || bypass;
        inst_data      = bypass ? imem_resp_data : (head_valid ? buf_data[rd_ptr] : '0);
        inst_pc        = bypass ? resp_pc : (head_valid ? buf_pc[rd_ptr] : '0);
        pop            = head_valid && inst_ready;
        push           = resp_keep && !(bypass && inst_ready);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight + CW'(fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                resp_pc  <= {redirect_pc[31:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                // Everything still outstanding after this cycle belongs to the old path.
                discard  <= inflight - CW'(imem_resp_valid);
            end else begin
                if (fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (imem_resp_valid && discard != '0)
                    discard <= discard - CW'(1);
                if (resp_keep)
                    resp_pc <= resp_pc + 32'd4;
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]   <= resp_pc;
            buf_data[wr_ptr] <= imem_resp_data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against a path/epoch-level fetch model
module tb_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif
    logic        clk = 0, reset = 1, redirect_valid = 0, inst_ready = 0;
    logic        imem_req_ready = 0, imem_resp_valid = 0;
    logic [31:0] redirect_pc = 0, imem_resp_data = 0;
    logic        imem_req_valid, inst_valid;
    logic [31:0] imem_req_addr, inst_data, inst_pc;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
    typedef struct { logic [31:0] pc; int arrived; } exp_t;
    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    int          cyc = 0, epoch = 0, resp_epoch = 0;
    int          tests = 0, fails = 0, fires = 0, pops = 0;
    int          lat_min = 1, lat_max = 1, ready_pct = 100, req_ready_pct = 100;
    logic [31:0] fa = RESET_PC;
    bit          after_rst = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5a5a_1234;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Memory model: answers the oldest accepted request once its latency has elapsed.
    task automatic step(input bit rst, input bit redir, input logic [31:0] rpc);
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_ready     = ($urandom_range(99) < ready_pct);
        imem_req_ready = ($urandom_range(99) < req_ready_pct);
        imem_resp_valid = 0;
        if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1;
            imem_resp_data  = word_at(mem_q[0].addr);
            resp_epoch      = mem_q[0].epoch;
            void'(mem_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic drain();
        ready_pct = 100;
        req_ready_pct = 0;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || mem_q.size() != 0); i++) step(0, 0, 0);
        chk(exp_q.size() == 0 && mem_q.size() == 0, "drain_timeout", 32'(exp_q.size()), 0);
    endtask

    // Monitor: the fetched stream after a reset/redirect to T must be T, T+4, ... with
    // every request made on an older path (epoch) silently dropped.
    always @(negedge clk) begin
        bit    erv, eiv;
        int    stale, k;
        mreq_t m;
        exp_t  e;
        if (reset) begin
            chk(!imem_req_valid, "req_valid_in_reset", 32'(imem_req_valid), 0);
            mem_q.delete();
            exp_q.delete();
            epoch++;
            fa = RESET_PC;
            after_rst = 1;
        end else begin
            if (after_rst) begin
                chk(!inst_valid && inst_data == 0 && inst_pc == 0, "reset_outputs", inst_data | inst_pc | 32'(inst_valid), 0);
                after_rst = 0;
            end
            if (imem_resp_valid && resp_epoch == epoch && !redirect_valid) begin
                k = -1;
                foreach (exp_q[i]) if (k < 0 && exp_q[i].arrived < 0) k = i;
                if (k >= 0) exp_q[k].arrived = cyc;
            end
            stale = (imem_resp_valid && resp_epoch != epoch) ? 1 : 0;
            foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
            erv = !redirect_valid && (exp_q.size() + stale < DEPTH);
            chk(imem_req_valid == erv, "req_valid", 32'(imem_req_valid), 32'(erv));
            if (imem_req_valid)
                chk(imem_req_addr == fa, "req_addr", imem_req_addr, fa);
            eiv = exp_q.size() > 0 && exp_q[0].arrived >= 0 && exp_q[0].arrived < cyc + BYP;
            chk(inst_valid == eiv, "inst_valid", 32'(inst_valid), 32'(eiv));
            if (inst_valid && exp_q.size() > 0) begin
                chk(inst_pc == exp_q[0].pc, "inst_pc", inst_pc, exp_q[0].pc);
                chk(inst_data == word_at(exp_q[0].pc), "inst_data", inst_data, word_at(exp_q[0].pc));
                if (inst_ready) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                m.addr  = imem_req_addr;
                m.due   = cyc + int'($urandom_range(lat_max, lat_min));
                m.epoch = epoch;
                mem_q.push_back(m);
                e.pc = fa;
                e.arrived = -1;
                exp_q.push_back(e);
                fa = fa + 32'd4;
                fires++;
            end
            if (redirect_valid) begin
                exp_q.delete();
                epoch++;
                fa = {redirect_pc[31:2], 2'b00};
            end
        end
        cyc++;
    end

    initial begin
        int p0, f0;
        bit rs;
        @(posedge clk);
        #1;
        step(1, 0, 0);
        step(1, 0, 0);
        // Streaming with 1-cycle memory: one instruction per cycle once filled.
        run(10);
        p0 = pops;
        run(20);
        chk(pops - p0 == 20, "throughput", 32'(pops - p0), 20);
        // Downstream stall: exactly DEPTH requests accepted, then drain and resume.
        drain();
        ready_pct = 0;
        req_ready_pct = 100;
        f0 = fires;
        run(12);
        chk(fires - f0 == DEPTH, "stall_fill", 32'(fires - f0), DEPTH);
        ready_pct = 100;
        run(20);
        chk(fires - f0 > DEPTH, "stall_resume", 32'(fires - f0), DEPTH + 1);
        // Redirects with requests in flight (3-cycle memory), including misaligned target.
        lat_min = 3;
        lat_max = 3;
        run(6);
        step(0, 1, 32'h10);
        run(3);
        step(0, 1, 32'h103);
        run(25);
        // Frequent redirects with 1-2 cycle memory so they collide with responses.
        lat_min = 1;
        lat_max = 2;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 32'h20 + 32'(i * 64));
            run(4);
        end
        // Address wrap with a toggling request ready.
        req_ready_pct = 50;
        step(0, 1, 32'hFFFF_FFF4);
        run(40);
        // Reset while the FIFO holds data and requests are in flight.
        req_ready_pct = 100;
        ready_pct = 0;
        lat_min = 3;
        lat_max = 3;
        run(6);
        step(1, 0, 0);
        ready_pct = 100;
        lat_min = 1;
        run(20);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                lat_min = 1;
                lat_max = int'($urandom_range(4, 1));
                ready_pct = int'($urandom_range(100, 30));
                req_ready_pct = int'($urandom_range(100, 30));
            end
            rs = ($urandom_range(199) == 0);
            step(rs, !rs && ($urandom_range(29) == 0),
                 ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(15)) : $urandom);
        end
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the single-cycle core's decode/execute path. Generates sequential fetch addresses, issues them to a pipelined instruction memory port with a valid/ready request handshake and in-order responses, buffers returned instructions with their PCs in a small FIFO, and hands them downstream through a valid/ready interface. A redirect from branch/jump resolution flushes the buffer, discards in-flight wrong-path responses and restarts fetch at the target.

## Interface
- DEPTH, 4, FIFO entries and maximum outstanding requests; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; polarity and synchronicity are fixed
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored (treated as 0)
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  word-aligned fetch address
- imem_req_ready  in  1  memory accepts request this cycle
- imem_resp_valid  in  1  response valid; responses arrive in request order, ≥1 cycle after acceptance
- imem_resp_data  in  32  instruction word
- inst_valid  out  1  instruction available downstream
- inst_data  out  32  instruction word
- inst_pc  out  32  PC of inst_data
- inst_ready  in  1  downstream consumes instruction this cycle

## Operation
- State: fetch_pc, resp_pc, FIFO (count, rd/wr pointers, entries of {pc, instr}), inflight counter, discard counter; counters are $clog2(DEPTH)+1 bits.
- Request issue: imem_req_valid = !reset && !redirect_valid && (count + inflight < DEPTH). imem_req_addr = fetch_pc. Request fires when valid && ready: fetch_pc += 4, inflight += 1. Address wraps modulo 2^32.
- Response: on imem_resp_valid, inflight -= 1. If discard > 0: drop response, discard -= 1. Otherwise write {resp_pc, data} into FIFO, resp_pc += 4. Credit rule guarantees the FIFO never overflows; no response is ever lost on the good path.
- Output: inst_valid = (count != 0); inst_data/inst_pc = FIFO head. Pop when inst_valid && inst_ready.
- Redirect (highest priority over all same-cycle updates except the downstream pop, which completes): FIFO cleared (count=0, pointers reset); fetch_pc = resp_pc = {redirect_pc[31:2],2'b00}; discard = inflight − (imem_resp_valid ? 1 : 0); any same-cycle response is dropped; no request issued in the redirect cycle. Redirect while discard > 0 accumulates correctly via the same formula.
- Simultaneous push and pop with FIFO full/empty handled: count unchanged on push+pop.
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, inst_valid 0, inst_data 0, inst_pc 0; fetch_pc = resp_pc = RESET_PC; count = inflight = discard = 0. Reset mid-operation abandons all in-flight requests; memory is reset alongside and returns no stale responses.

## Timing
- First request: cycle after reset deasserts, address RESET_PC.
- Response in cycle N → inst_valid in N+1 (non-bypass build).
- Redirect in cycle N → first new request in N+1 at target; target instruction visible no earlier than response cycle +1.
- Steady state with 1-cycle memory and inst_ready=1: one instruction per cycle.
- inst_* stable while inst_valid && !inst_ready (except on redirect or reset).

## Configuration
- FETCH_BYPASS_EN defined: when FIFO is empty and a non-discarded response arrives, inst_valid/inst_data/inst_pc are driven combinationally from the response in the same cycle; if inst_ready is also high, the entry is not written to the FIFO; otherwise it is written as normal. Zero-cycle response-to-output latency.
- Undefined: all responses pass through the FIFO; one cycle of latency; no combinational path from imem_resp_* to inst_*.

## Test plan
- Reset, memory with 1-cycle latency, inst_ready=1 → requests 0x0,0x4,0x8,…; inst_pc 0x0,0x4,0x8 with matching data, one per cycle after fill.
- inst_ready=0 with DEPTH=4 → exactly 4 requests accepted, then imem_req_valid=0; raise inst_ready → instructions drain in order, requests resume.
- 2 requests in flight (0x10,0x14), redirect_pc=0x103 → next request 0x100; both old responses dropped; first inst_pc=0x100.
- Redirect in same cycle as response for 0x20 with 1 other in flight → discard=1; that response and the next dropped; no wrong-path inst_valid.
- imem_req_ready toggling 0/1 and fetch_pc at 0xFFFF_FFFC → addresses held while not ready, wrap to 0x0, no duplicates or gaps.
- Reset asserted with full FIFO and inflight=2 → next cycle inst_valid=0, imem_req_valid=0; after release first request RESET_PC; with FETCH_BYPASS_EN, response with empty FIFO shows inst_valid same cycle.
